gpu_reg_arbiter: RTL and testbench

GPU_REG_ARBITER -- requirements
Module: gpu_reg_arbiter

---
 rtl/gpu_reg_arbiter.sv | 125 ++++++++++++
 tb/tb_gpu_reg_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpu_reg_arbiter.sv
// Two-requester arbiter in front of a single-port register file. Each access runs IDLE -> ISSUE -> RESP.
// Define GPU_REG_ARB_ROUND_ROBIN_EN for round-robin tie-breaking; without it requester 0 wins ties.
module gpu_reg_arbiter #(
  parameter int BYTES_PER_REG = 4,
  parameter int REG_COUNT     = 32,
  localparam int WIDTH        = 8 * BYTES_PER_REG,
  localparam int ADDR_BITS    = $clog2(REG_COUNT * BYTES_PER_REG)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [1:0]                 m_valid_i,
  output logic [1:0]                 m_ready_o,
  input  logic [2*ADDR_BITS-1:0]     m_addr_i,
  input  logic [2*WIDTH-1:0]         m_wdata_i,
  input  logic [2*BYTES_PER_REG-1:0] m_we_i,
  output logic [1:0]                 m_rvalid_o,
  output logic [WIDTH-1:0]           m_rdata_o,
  output logic                       reg_en_o,
  output logic [ADDR_BITS-1:0]       reg_addr_o,
  output logic [WIDTH-1:0]           reg_din_o,
  output logic [BYTES_PER_REG-1:0]   reg_we_o,
  input  logic [WIDTH-1:0]           reg_dout_i
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t                     r_state;
  logic                       r_win;
  logic                       r_en;
  logic [ADDR_BITS-1:0]       r_addr;
  logic [WIDTH-1:0]           r_din;
  logic [BYTES_PER_REG-1:0]   r_we;
  logic [1:0]                 r_rvalid;
  logic [WIDTH-1:0]           r_rdata;
`ifdef GPU_REG_ARB_ROUND_ROBIN_EN
  logic                       r_last_grant;
`endif

  logic [ADDR_BITS-1:0]       w_addr  [2];
  logic [WIDTH-1:0]           w_wdata [2];
  logic [BYTES_PER_REG-1:0]   w_we    [2];
  logic                       w_win;
  logic                       w_accept;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_unpack
      assign w_addr[gi]  = m_addr_i[gi*ADDR_BITS +: ADDR_BITS];
      assign w_wdata[gi] = m_wdata_i[gi*WIDTH +: WIDTH];
      assign w_we[gi]    = m_we_i[gi*BYTES_PER_REG +: BYTES_PER_REG];
    end
  endgenerate

  // A lone valid always wins; only a tie consults the policy.
  always_comb begin
    w_win = ~m_valid_i[0];
`ifdef GPU_REG_ARB_ROUND_ROBIN_EN
    if (m_valid_i == 2'b11) begin
      w_win = ~r_last_grant;
    end
`endif
  end

  // Ready is combinational so a command can be taken in the same cycle valid appears.
  assign m_ready_o = (r_state == IDLE && !rst_i && m_valid_i[w_win]) ?
                     (w_win ? 2'b10 : 2'b01) : 2'b00;
  assign w_accept  = |m_ready_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= IDLE;
      r_win    <= 1'b0;
      r_en     <= 1'b0;
      r_addr   <= '0;
      r_din    <= '0;
      r_we     <= '0;
      r_rvalid <= 2'b00;
      r_rdata  <= '0;
`ifdef GPU_REG_ARB_ROUND_ROBIN_EN
      r_last_grant <= 1'b1;
`endif
    end else begin
      r_rvalid <= 2'b00;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state <= ISSUE;
            r_en    <= 1'b1;
            r_addr  <= w_addr[w_win];
            r_din   <= w_wdata[w_win];
            r_we    <= w_we[w_win];
            r_win   <= w_win;
`ifdef GPU_REG_ARB_ROUND_ROBIN_EN
            r_last_grant <= w_win;
`endif
          end
        end
        ISSUE: begin
          r_state <= RESP;
          r_en    <= 1'b0;
          r_we    <= '0;
        end
        RESP: begin
          // Register file data is valid now, one cycle after the enable.
          r_state  <= IDLE;
          r_rdata  <= reg_dout_i;
          r_rvalid <= r_win ? 2'b10 : 2'b01;
        end
        default: begin
          r_state <= IDLE;
          r_en    <= 1'b0;
          r_we    <= '0;
        end
      endcase
    end
  end

  assign reg_en_o   = r_en;
  assign reg_addr_o = r_addr;
  assign reg_din_o  = r_din;
  assign reg_we_o   = r_we;
  assign m_rvalid_o = r_rvalid;
  assign m_rdata_o  = r_rdata;

endmodule

// File: tb/tb_gpu_reg_arbiter.sv
// Bench for gpu_reg_arbiter: directed scenarios plus a cycle-level transaction model checked every cycle.
// Honours GPU_REG_ARB_ROUND_ROBIN_EN for the expected tie-break order.
module tb_gpu_reg_arbiter;
  localparam int BPR = 4;
  localparam int RC  = 32;
  localparam int W   = 32;
  localparam int AB  = 7;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b1;
  logic [1:0]        m_valid_i = '0;
  logic [1:0]        m_ready_o;
  logic [2*AB-1:0]   m_addr_i = '0;
  logic [2*W-1:0]    m_wdata_i = '0;
  logic [2*BPR-1:0]  m_we_i = '0;
  logic [1:0]        m_rvalid_o;
  logic [W-1:0]      m_rdata_o;
  logic              reg_en_o;
  logic [AB-1:0]     reg_addr_o;
  logic [W-1:0]      reg_din_o;
  logic [BPR-1:0]    reg_we_o;
  logic [W-1:0]      reg_dout_i = '0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rst_cnt = 0;

  gpu_reg_arbiter #(.BYTES_PER_REG(BPR), .REG_COUNT(RC)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m_valid_i(m_valid_i), .m_ready_o(m_ready_o),
    .m_addr_i(m_addr_i), .m_wdata_i(m_wdata_i), .m_we_i(m_we_i),
    .m_rvalid_o(m_rvalid_o), .m_rdata_o(m_rdata_o),
    .reg_en_o(reg_en_o), .reg_addr_o(reg_addr_o), .reg_din_o(reg_din_o),
    .reg_we_o(reg_we_o), .reg_dout_i(reg_dout_i)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc++;
  always @(posedge rst_i) rst_cnt++;

  function automatic logic [W-1:0] init_val(input int i);
    return (i == 1) ? 32'h0000_00A5 : 32'h1000_0000 + i;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Register file stand-in: synchronous read-before-write with byte enables.
  logic [W-1:0] mem [RC];
  initial for (int i = 0; i < RC; i++) mem[i] = init_val(i);
  always @(posedge clk_i) begin
    if (reg_en_o) begin
      reg_dout_i <= mem[reg_addr_o[AB-1:2]];
      for (int b = 0; b < BPR; b++)
        if (reg_we_o[b]) mem[reg_addr_o[AB-1:2]][b*8 +: 8] <= reg_din_o[b*8 +: 8];
    end
  end

  // Model: an accept at cycle T means enable at T+1, response at T+3, requester idle again from T+3.
  logic [W-1:0]   arch [RC];
  int             m_last_acc = -100;
  int             m_win = 0;
  int             m_last = 1;
  int             rst_seen = 0;
  logic [AB-1:0]  m_addr;
  logic [W-1:0]   m_wdata;
  logic [BPR-1:0] m_we;
  logic [W-1:0]   m_pend;
  logic [W-1:0]   m_rdata = '0;

  initial begin
    logic [1:0]     e_ready;
    logic [1:0]     e_rv;
    logic           e_en;
    int             win;
    int             idx;
    for (int i = 0; i < RC; i++) arch[i] = init_val(i);
    forever begin
      @(negedge clk_i);
      if (rst_i || rst_cnt != rst_seen) begin
        rst_seen   = rst_cnt;
        m_last_acc = -100;
        m_rdata    = '0;
        m_last     = 1;
      end
      if (rst_i) begin
        chk("rst_ready", m_ready_o, 2'b00);
        chk("rst_en", reg_en_o, 1'b0);
        chk("rst_we", reg_we_o, '0);
        chk("rst_rvalid", m_rvalid_o, 2'b00);
        chk("rst_rdata", m_rdata_o, '0);
      end else begin
        e_ready = 2'b00;
        win = 0;
        if (cyc - m_last_acc >= 3) begin
          if (m_valid_i == 2'b11) begin
`ifdef GPU_REG_ARB_ROUND_ROBIN_EN
            win = (m_last == 0) ? 1 : 0;
`else
            win = 0;
`endif
            e_ready = (win == 1) ? 2'b10 : 2'b01;
          end else if (m_valid_i[0]) begin
            e_ready = 2'b01;
          end else if (m_valid_i[1]) begin
            e_ready = 2'b10;
            win = 1;
          end
        end
        chk("ready", m_ready_o, e_ready);

        e_en = (cyc == m_last_acc + 1);
        chk("reg_en", reg_en_o, e_en);
        chk("reg_we", reg_we_o, e_en ? m_we : '0);
        if (e_en) begin
          chk("reg_addr", reg_addr_o, m_addr);
          chk("reg_din", reg_din_o, m_wdata);
          idx = int'(m_addr[AB-1:2]);
          m_pend = arch[idx];
          for (int b = 0; b < BPR; b++)
            if (m_we[b]) arch[idx][b*8 +: 8] = m_wdata[b*8 +: 8];
        end

        e_rv = 2'b00;
        if (cyc == m_last_acc + 3) begin
          e_rv = (m_win == 1) ? 2'b10 : 2'b01;
          m_rdata = m_pend;
          $display("txn: cycle %0d req%0d addr %0h we %0h rdata %08h", cyc, m_win, m_addr, m_we, m_rdata);
        end
        chk("rvalid", m_rvalid_o, e_rv);
        chk("rdata", m_rdata_o, m_rdata);

        if (e_ready != 2'b00) begin
          m_last_acc = cyc;
          m_win   = win;
          m_last  = win;
          m_addr  = (win == 1) ? m_addr_i[AB +: AB] : m_addr_i[0 +: AB];
          m_wdata = (win == 1) ? m_wdata_i[W +: W] : m_wdata_i[0 +: W];
          m_we    = (win == 1) ? m_we_i[BPR +: BPR] : m_we_i[0 +: BPR];
        end
      end
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input int r, input logic [AB-1:0] a, input logic [W-1:0] d, input logic [BPR-1:0] we);
    m_addr_i[r*AB +: AB]    = a;
    m_wdata_i[r*W +: W]     = d;
    m_we_i[r*BPR +: BPR]    = we;
    m_valid_i[r]            = 1'b1;
  endtask

  task automatic wait_acc(input int r, output int c);
    c = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk_i);
      if (m_valid_i[r] && m_ready_o[r]) begin
        c = cyc;
        break;
      end
    end
    if (c < 0) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout req%0d: got no accept expected one within 20 cycles", r);
    end
  endtask

  task automatic wait_any(output int w, output int c);
    c = -1;
    w = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk_i);
      if ((m_valid_i & m_ready_o) != 2'b00) begin
        c = cyc;
        w = m_ready_o[1] ? 1 : 0;
        break;
      end
    end
    if (c < 0) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout any: got no accept expected one within 20 cycles");
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int t, t1, t2, w;
    int g [4];
    int ac [3];
    int exp_g [4];
`ifdef GPU_REG_ARB_ROUND_ROBIN_EN
    exp_g = '{0, 1, 0, 1};
`else
    exp_g = '{0, 0, 0, 0};
`endif

    // Reset: ready stays low even with a valid present
    m_valid_i = 2'b01;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_ready_lit", m_ready_o, 2'b00);
    chk("rst_addr_lit", reg_addr_o, '0);
    chk("rst_din_lit", reg_din_o, '0);
    m_valid_i = 2'b00;
    step();
    rst_i = 1'b0;

    // Single read of 0x4
    drive(0, 7'h04, 32'h0, 4'h0);
    wait_acc(0, t);
    step();
    m_valid_i[0] = 1'b0;
    @(negedge clk_i);
    chk("rd_en_t1", reg_en_o, 1'b1);
    chk("rd_addr_t1", reg_addr_o, 7'h04);
    chk("rd_we_t1", reg_we_o, 4'h0);
    step();
    @(negedge clk_i);
    chk("rd_en_t2", reg_en_o, 1'b0);
    step();
    @(negedge clk_i);
    chk("rd_rvalid_t3", m_rvalid_o, 2'b01);
    chk("rd_rdata_t3", m_rdata_o, 32'h0000_00A5);

    // Write from requester 1; response carries the pre-write value
    step();
    drive(1, 7'h04, 32'hDEAD_BEEF, 4'hF);
    wait_acc(1, t);
    step();
    m_valid_i[1] = 1'b0;
    @(negedge clk_i);
    chk("wr_we_t1", reg_we_o, 4'hF);
    chk("wr_din_t1", reg_din_o, 32'hDEAD_BEEF);
    step();
    step();
    @(negedge clk_i);
    chk("wr_rvalid_t3", m_rvalid_o, 2'b10);
    chk("wr_rdata_t3", m_rdata_o, 32'h0000_00A5);

    // Contention: both requesters valid for four transactions
    step();
    drive(0, 7'h08, 32'h0, 4'h0);
    drive(1, 7'h0C, 32'h0, 4'h0);
    for (int k = 0; k < 4; k++) begin
      wait_any(w, t);
      g[k] = w;
    end
    step();
    m_valid_i = 2'b00;
    for (int k = 0; k < 4; k++) chk($sformatf("grant%0d", k), 64'(g[k]), 64'(exp_g[k]));
    repeat (3) step();

    // Late valid from requester 1 during requester 0's ISSUE cycle
    drive(0, 7'h10, 32'h0, 4'h0);
    wait_acc(0, t);
    step();
    m_valid_i[0] = 1'b0;
    drive(1, 7'h14, 32'h0, 4'h0);
    @(negedge clk_i);
    chk("late_ready_t1", m_ready_o[1], 1'b0);
    step();
    @(negedge clk_i);
    chk("late_ready_t2", m_ready_o[1], 1'b0);
    wait_acc(1, t1);
    chk("late_acc_delay", 64'(t1 - t), 64'd3);
    step();
    m_valid_i[1] = 1'b0;
    repeat (3) step();

    // Asynchronous reset pulse in the ISSUE cycle
    drive(0, 7'h18, 32'h0, 4'h0);
    wait_acc(0, t);
    step();
    drive(0, 7'h1C, 32'h0, 4'h0);
    #1 rst_i = 1'b1;
    #1;
    chk("arst_en_fall", reg_en_o, 1'b0);
    chk("arst_ready", m_ready_o, 2'b00);
    #1 rst_i = 1'b0;
    wait_acc(0, t2);
    chk("arst_reaccept", 64'(t2 - t), 64'd1);
    step();
    m_valid_i[0] = 1'b0;
    step();
    @(negedge clk_i);
    chk("arst_no_rvalid", m_rvalid_o, 2'b00);
    step();
    @(negedge clk_i);
    chk("arst_new_rvalid", m_rvalid_o, 2'b01);
    chk("arst_new_rdata", m_rdata_o, 32'h1000_0007);

    // Back-to-back reads of 0x0 from requester 0
    step();
    drive(0, 7'h00, 32'h0, 4'h0);
    for (int k = 0; k < 3; k++) wait_acc(0, ac[k]);
    step();
    m_valid_i[0] = 1'b0;
    chk("b2b_gap1", 64'(ac[1] - ac[0]), 64'd3);
    chk("b2b_gap2", 64'(ac[2] - ac[1]), 64'd3);
    repeat (5) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
